// File: rtl/cfg_write_scheduler_if.sv
// Host/automation request ports and synth config outputs of cfg_write_scheduler.
interface cfg_write_scheduler_if;
  logic       host_valid;
  logic       host_ready;
  logic [3:0] host_addr;
  logic [7:0] host_data;
  logic       auto_valid;
  logic       auto_ready;
  logic [3:0] auto_addr;
  logic [7:0] auto_data;
  logic [7:0] cfg_data;
  logic [3:0] cfg_addr;
  logic       cfg_strobe;
  logic       busy;
  logic [3:0] fifo_count;

  modport master (
    output host_valid, host_addr, host_data,
    output auto_valid, auto_addr, auto_data,
    input  host_ready, auto_ready,
    input  cfg_data, cfg_addr, cfg_strobe, busy, fifo_count
  );

  modport slave (
    input  host_valid, host_addr, host_data,
    input  auto_valid, auto_addr, auto_data,
    output host_ready, auto_ready,
    output cfg_data, cfg_addr, cfg_strobe, busy, fifo_count
  );
endinterface

// File: rtl/cfg_write_scheduler.sv
// Serialises host (FIFO-buffered) and automation writes onto the synth cfg bus with a
// SETUP/HIGH/LOW strobe sequence. Define CFG_WRITE_SCHEDULER_RR_EN for round-robin arbitration.
module cfg_write_scheduler #(
  parameter int unsigned SETUP_CYCLES = 1,
  parameter int unsigned HIGH_CYCLES  = 3,
  parameter int unsigned LOW_CYCLES   = 3,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input logic                  clk,
  input logic                  reset,
  cfg_write_scheduler_if.slave bus
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, SETUP, HIGH, LOW} state_t;

  state_t           state, state_nx;
  logic [2:0]       phase, phase_nx;
  logic [3:0]       fifo_addr_mem [FIFO_DEPTH];
  logic [7:0]       fifo_data_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [3:0]       count;
  logic             push, pop, host_pending;
  logic             grant_host, grant_auto;
  logic             strobe_q;
  logic [3:0]       addr_q;
  logic [7:0]       data_q;
`ifdef CFG_WRITE_SCHEDULER_RR_EN
  logic             last_auto;
`endif

  assign bus.host_ready = (count != 4'(FIFO_DEPTH));
  assign bus.fifo_count = count;
  assign bus.busy       = (state != IDLE);
  assign bus.auto_ready = grant_auto & ~reset;
  assign bus.cfg_strobe = strobe_q;
  assign bus.cfg_addr   = addr_q;
  assign bus.cfg_data   = data_q;

  assign push         = bus.host_valid & bus.host_ready;
  assign pop          = grant_host;
  assign host_pending = (count != '0);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_mem[wr_ptr] <= bus.host_addr;
      fifo_data_mem[wr_ptr] <= bus.host_data;
    end
  end

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + 4'd1;
        2'b01:   count <= count - 4'd1;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    grant_host = 1'b0;
    grant_auto = 1'b0;
    if (state == IDLE) begin
`ifdef CFG_WRITE_SCHEDULER_RR_EN
      if (host_pending && (!bus.auto_valid || last_auto)) grant_host = 1'b1;
      else if (bus.auto_valid)                             grant_auto = 1'b1;
`else
      if (bus.auto_valid)    grant_auto = 1'b1;
      else if (host_pending) grant_host = 1'b1;
`endif
    end
  end

  // phase counts down the remaining cycles of the current state and is reloaded on entry.
  always_comb begin
    state_nx = state;
    phase_nx = phase;
    case (state)
      IDLE: begin
        if (grant_host || grant_auto) begin
          state_nx = SETUP;
          phase_nx = 3'(SETUP_CYCLES - 1);
        end
      end
      SETUP: begin
        if (phase == '0) begin
          state_nx = HIGH;
          phase_nx = 3'(HIGH_CYCLES - 1);
        end else begin
          phase_nx = phase - 3'd1;
        end
      end
      HIGH: begin
        if (phase == '0) begin
          state_nx = LOW;
          phase_nx = 3'(LOW_CYCLES - 1);
        end else begin
          phase_nx = phase - 3'd1;
        end
      end
      LOW: begin
        if (phase == '0) begin
          state_nx = IDLE;
          phase_nx = '0;
        end else begin
          phase_nx = phase - 3'd1;
        end
      end
      default: begin
        state_nx = IDLE;
        phase_nx = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      phase    <= '0;
      strobe_q <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
`ifdef CFG_WRITE_SCHEDULER_RR_EN
      last_auto <= 1'b1;
`endif
    end else begin
      state    <= state_nx;
      phase    <= phase_nx;
      strobe_q <= (state_nx == HIGH);
      if (grant_host) begin
        addr_q <= fifo_addr_mem[rd_ptr];
        data_q <= fifo_data_mem[rd_ptr];
      end else if (grant_auto) begin
        addr_q <= bus.auto_addr;
        data_q <= bus.auto_data;
      end
`ifdef CFG_WRITE_SCHEDULER_RR_EN
      if (grant_host || grant_auto) last_auto <= grant_auto;
`endif
    end
  end

endmodule

// File: tb/tb_cfg_write_scheduler.sv
// Self-checking bench for cfg_write_scheduler: directed scenarios plus randomized batches
// checked against a transaction-level arbitration/timing model.
module tb_cfg_write_scheduler;

  localparam int S = 1;
  localparam int H = 3;
  localparam int L = 3;
  localparam int P = S + H + L + 1;
`ifdef CFG_WRITE_SCHEDULER_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  cfg_write_scheduler_if m ();
  cfg_write_scheduler_if ma ();

  cfg_write_scheduler #(.SETUP_CYCLES(S), .HIGH_CYCLES(H), .LOW_CYCLES(L), .FIFO_DEPTH(4))
    u_dut (.clk(clk), .reset(reset), .bus(m.slave));

  cfg_write_scheduler #(.SETUP_CYCLES(2), .HIGH_CYCLES(4), .LOW_CYCLES(5), .FIFO_DEPTH(4))
    u_alt (.clk(clk), .reset(reset), .bus(ma.slave));

  int          errors = 0;
  int          checks = 0;
  int          cyc    = 0;
  bit          model_last_auto = 1'b1;
  int          rise_cyc[$];
  logic [11:0] rise_pay[$];
  int          ardy_cyc[$];
  logic        prev_strobe = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (m.cfg_strobe && !prev_strobe) begin
      rise_cyc.push_back(cyc);
      rise_pay.push_back({m.cfg_addr, m.cfg_data});
    end
    if (m.auto_ready) ardy_cyc.push_back(cyc);
    prev_strobe = m.cfg_strobe;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic clear_logs();
    rise_cyc.delete();
    rise_pay.delete();
    ardy_cyc.delete();
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    model_last_auto = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    m.host_valid = 1'b1; m.host_addr = 4'h3; m.host_data = 8'h11;
    m.auto_valid = 1'b1; m.auto_addr = 4'h4; m.auto_data = 8'h22;
    @(negedge clk);
    checks++; if (m.cfg_strobe !== 1'b0) begin errors++; $display("FAIL rst_strobe: got %b expected 0", m.cfg_strobe); end
    checks++; if (m.cfg_addr !== 4'h0) begin errors++; $display("FAIL rst_addr: got %h expected 0", m.cfg_addr); end
    checks++; if (m.cfg_data !== 8'h00) begin errors++; $display("FAIL rst_data: got %h expected 00", m.cfg_data); end
    checks++; if (m.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", m.busy); end
    checks++; if (m.auto_ready !== 1'b0) begin errors++; $display("FAIL rst_auto_ready: got %b expected 0", m.auto_ready); end
    checks++; if (m.fifo_count !== 4'd0) begin errors++; $display("FAIL rst_fifo_count: got %0d expected 0", m.fifo_count); end
    checks++; if (m.host_ready !== 1'b1) begin errors++; $display("FAIL rst_host_ready: got %b expected 1", m.host_ready); end
    m.host_valid = 1'b0;
    m.auto_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    model_last_auto = 1'b1;
  endtask

  // Push one host write; cycle g (grant) is the first cycle the entry sits in the FIFO.
  task automatic test_single_write(input logic [3:0] a, input logic [7:0] d, input string tag);
    bit exp_s, exp_b;
    @(posedge clk); #1;
    m.host_valid = 1'b1; m.host_addr = a; m.host_data = d;
    @(posedge clk); #1;
    m.host_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      exp_s = (k >= 2 && k <= 4);
      exp_b = (k >= 1 && k <= 7);
      checks++; if (m.cfg_strobe !== exp_s) begin errors++; $display("FAIL %s strobe k=%0d: got %b expected %b", tag, k, m.cfg_strobe, exp_s); end
      checks++; if (m.busy !== exp_b) begin errors++; $display("FAIL %s busy k=%0d: got %b expected %b", tag, k, m.busy, exp_b); end
      if (k >= 1) begin
        checks++;
        if ({m.cfg_addr, m.cfg_data} !== {a, d}) begin
          errors++; $display("FAIL %s payload k=%0d: got %h expected %h", tag, k, {m.cfg_addr, m.cfg_data}, {a, d});
        end
      end
    end
  endtask

  task automatic test_fifo_full();
    int c0;
    clear_logs();
    @(posedge clk); #1;
    c0 = cyc;
    m.auto_valid = 1'b1; m.auto_addr = 4'hC; m.auto_data = 8'h9E;
    @(negedge clk);
    checks++; if (m.auto_ready !== 1'b1) begin errors++; $display("FAIL full_auto_grant: got %b expected 1", m.auto_ready); end
    @(posedge clk); #1;
    m.auto_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      m.host_valid = 1'b1; m.host_addr = 4'(i); m.host_data = 8'(8'h10 + i);
      if (i == 4) begin
        @(negedge clk);
        checks++; if (m.host_ready !== 1'b0) begin errors++; $display("FAIL full_host_ready: got %b expected 0", m.host_ready); end
        checks++; if (m.fifo_count !== 4'd4) begin errors++; $display("FAIL full_fifo_count: got %0d expected 4", m.fifo_count); end
      end
      @(posedge clk); #1;
    end
    m.host_valid = 1'b0;
    for (int n = 0; n < 200 && cyc < c0 + 40; n++) @(negedge clk);
    checks++; if (rise_cyc.size() != 5) begin errors++; $display("FAIL full_write_count: got %0d expected 5", rise_cyc.size()); end
    for (int i = 0; i < 5 && i < rise_cyc.size(); i++) begin
      checks++;
      if (rise_cyc[i] != c0 + 2 + 8 * i) begin
        errors++; $display("FAIL full_rise_%0d: got cycle %0d expected %0d", i, rise_cyc[i] - c0, 2 + 8 * i);
      end
      checks++;
      if (i == 0 && rise_pay[i] !== 12'hC9E) begin
        errors++; $display("FAIL full_pay_0: got %h expected c9e", rise_pay[i]);
      end else if (i > 0 && rise_pay[i] !== {4'(i - 1), 8'(8'h10 + i - 1)}) begin
        errors++; $display("FAIL full_pay_%0d: got %h expected %h", i, rise_pay[i], {4'(i - 1), 8'(8'h10 + i - 1)});
      end
    end
    checks++; if (m.busy !== 1'b0) begin errors++; $display("FAIL full_end_busy: got %b expected 0", m.busy); end
    checks++; if (m.fifo_count !== 4'd0) begin errors++; $display("FAIL full_end_count: got %0d expected 0", m.fifo_count); end
    model_last_auto = 1'b0;
  endtask

  // Host items are pushed one per cycle from c0; automation requests are presented from
  // c0+a_off and each is held until its grant. Host data bit 7 is 0, automation bit 7 is 1.
  task automatic run_batch(input int nh, input int na, input int a_off, input string tag, output int c0);
    logic [11:0] hq[$];
    logic [11:0] aq[$];
    logic [11:0] ep[$];
    int          eg[$];
    int          eag[$];
    int          t, hg, ag, lim, idle_at, n;
    bit          hp, ap, pick_auto;
    for (int i = 0; i < nh; i++) hq.push_back({4'($urandom_range(0, 15)), 1'b0, 7'($urandom_range(0, 127))});
    for (int i = 0; i < na; i++) aq.push_back({4'($urandom_range(0, 15)), 1'b1, 7'($urandom_range(0, 127))});
    t = 0; hg = 0; ag = 0;
    while (hg < nh || ag < na) begin
      hp = (hg < ((t < nh) ? t : nh));
      ap = (ag < na) && (t >= a_off);
      if (!hp && !ap) begin
        t++;
      end else begin
        pick_auto = RR ? (ap && !(hp && model_last_auto)) : ap;
        eg.push_back(t);
        if (pick_auto) begin
          ep.push_back(aq[ag]); eag.push_back(t); ag++;
        end else begin
          ep.push_back(hq[hg]); hg++;
        end
        model_last_auto = pick_auto;
        t += P;
      end
    end
    lim = (nh + na + 2) * P + 20;
    clear_logs();
    @(posedge clk); #1;
    c0 = cyc;
    fork
      begin
        for (int i = 0; i < nh; i++) begin
          m.host_valid = 1'b1;
          {m.host_addr, m.host_data} = hq[i];
          checks++; if (m.host_ready !== 1'b1) begin errors++; $display("FAIL %s host_ready push %0d: got %b expected 1", tag, i, m.host_ready); end
          @(posedge clk); #1;
        end
        m.host_valid = 1'b0;
      end
      begin
        repeat (a_off) begin @(posedge clk); #1; end
        for (int j = 0; j < na; j++) begin
          m.auto_valid = 1'b1;
          {m.auto_addr, m.auto_data} = aq[j];
          n = 0;
          @(negedge clk);
          while (m.auto_ready !== 1'b1 && n < lim) begin @(negedge clk); n++; end
          if (n >= lim) begin checks++; errors++; $display("FAIL %s auto_ready timeout item %0d: got no grant expected grant", tag, j); end
          @(posedge clk); #1;
        end
        m.auto_valid = 1'b0;
      end
    join
    idle_at = c0 + eg[eg.size() - 1] + P;
    for (int k = 0; k < 4 * lim && cyc < idle_at; k++) @(negedge clk);
    checks++; if (m.busy !== 1'b0) begin errors++; $display("FAIL %s end_busy: got %b expected 0", tag, m.busy); end
    checks++; if (m.fifo_count !== 4'd0) begin errors++; $display("FAIL %s end_count: got %0d expected 0", tag, m.fifo_count); end
    checks++; if (rise_cyc.size() != eg.size()) begin errors++; $display("FAIL %s write_count: got %0d expected %0d", tag, rise_cyc.size(), eg.size()); end
    for (int k = 0; k < eg.size() && k < rise_cyc.size(); k++) begin
      checks++; if (rise_cyc[k] != c0 + eg[k] + S + 1) begin errors++; $display("FAIL %s rise_%0d: got cycle %0d expected %0d", tag, k, rise_cyc[k] - c0, eg[k] + S + 1); end
      checks++; if (rise_pay[k] !== ep[k]) begin errors++; $display("FAIL %s pay_%0d: got %h expected %h", tag, k, rise_pay[k], ep[k]); end
    end
    checks++; if (ardy_cyc.size() != eag.size()) begin errors++; $display("FAIL %s auto_ready_count: got %0d expected %0d", tag, ardy_cyc.size(), eag.size()); end
    for (int k = 0; k < eag.size() && k < ardy_cyc.size(); k++) begin
      checks++; if (ardy_cyc[k] != c0 + eag[k]) begin errors++; $display("FAIL %s auto_ready_%0d: got cycle %0d expected %0d", tag, k, ardy_cyc[k] - c0, eag[k]); end
    end
  endtask

  task automatic test_auto_while_busy();
    int c0;
    run_batch(1, 1, 3, "auto_busy", c0);
    checks++; if (ardy_cyc.size() != 1) begin errors++; $display("FAIL auto_busy_pulses: got %0d expected 1", ardy_cyc.size()); end
    if (ardy_cyc.size() > 0) begin
      checks++; if (ardy_cyc[0] - c0 != 9) begin errors++; $display("FAIL auto_busy_pulse_cycle: got %0d expected 9", ardy_cyc[0] - c0); end
    end
  endtask

  task automatic test_reset_in_high();
    int c0;
    clear_logs();
    @(posedge clk); #1;
    c0 = cyc;
    for (int i = 0; i < 3; i++) begin
      m.host_valid = 1'b1; m.host_addr = 4'h9; m.host_data = 8'(8'h3C + i);
      @(posedge clk); #1;
    end
    m.host_valid = 1'b0;
    for (int n = 0; n < 20 && cyc < c0 + 4; n++) @(negedge clk);
    checks++; if (m.cfg_strobe !== 1'b1) begin errors++; $display("FAIL rhigh_pre_strobe: got %b expected 1", m.cfg_strobe); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (m.cfg_strobe !== 1'b0) begin errors++; $display("FAIL rhigh_strobe: got %b expected 0", m.cfg_strobe); end
    checks++; if (m.busy !== 1'b0) begin errors++; $display("FAIL rhigh_busy: got %b expected 0", m.busy); end
    checks++; if (m.fifo_count !== 4'd0) begin errors++; $display("FAIL rhigh_fifo_count: got %0d expected 0", m.fifo_count); end
    checks++; if (m.host_ready !== 1'b1) begin errors++; $display("FAIL rhigh_host_ready: got %b expected 1", m.host_ready); end
    checks++; if (m.cfg_addr !== 4'h0) begin errors++; $display("FAIL rhigh_addr: got %h expected 0", m.cfg_addr); end
    @(posedge clk); #1;
    reset = 1'b0;
    model_last_auto = 1'b1;
    test_single_write(4'h5, 8'hA7, "post_rst");
    model_last_auto = 1'b0;
  endtask

  task automatic test_arbitration();
    int    c0;
    string obs, exp_order;
    do_reset();
    run_batch(3, 3, 1, "arb", c0);
    obs = "";
    for (int k = 0; k < rise_pay.size(); k++) obs = {obs, (rise_pay[k][7] ? "A" : "H")};
    exp_order = RR ? "HAHAHA" : "AAAHHH";
    checks++; if (obs != exp_order) begin errors++; $display("FAIL arb_order: got %s expected %s", obs, exp_order); end
  endtask

  task automatic test_random();
    int c0, nh, na, off;
    for (int b = 0; b < 10; b++) begin
      nh  = $urandom_range(0, 4);
      na  = $urandom_range(0, 3);
      off = $urandom_range(0, 2);
      if (nh == 0 && na == 0) nh = 1;
      run_batch(nh, na, off, $sformatf("rand%0d", b), c0);
    end
  endtask

  // Alternate timing instance: SETUP=2, HIGH=4, LOW=5 gives a 12-cycle write period.
  task automatic test_alt_timing();
    bit exp_s;
    @(posedge clk); #1;
    ma.host_valid = 1'b1; ma.host_addr = 4'h3; ma.host_data = 8'h5A;
    @(posedge clk); #1;
    ma.host_addr = 4'h6; ma.host_data = 8'hC3;
    @(posedge clk); #1;
    ma.host_valid = 1'b0;
    for (int k = 1; k < 21; k++) begin
      @(negedge clk);
      exp_s = (k >= 3 && k <= 6) || (k >= 15 && k <= 18);
      checks++; if (ma.cfg_strobe !== exp_s) begin errors++; $display("FAIL alt strobe k=%0d: got %b expected %b", k, ma.cfg_strobe, exp_s); end
      if (k == 2) begin
        checks++; if ({ma.cfg_addr, ma.cfg_data} !== 12'h35A) begin errors++; $display("FAIL alt first_payload: got %h expected 35a", {ma.cfg_addr, ma.cfg_data}); end
      end
      if (k == 12) begin
        checks++; if (ma.busy !== 1'b0) begin errors++; $display("FAIL alt idle_at_12: got %b expected 0", ma.busy); end
      end
      if (k == 13) begin
        checks++; if ({ma.cfg_addr, ma.cfg_data} !== 12'h6C3) begin errors++; $display("FAIL alt second_payload: got %h expected 6c3", {ma.cfg_addr, ma.cfg_data}); end
      end
    end
  endtask

  initial begin
    m.host_valid = 1'b0; m.host_addr = '0; m.host_data = '0;
    m.auto_valid = 1'b0; m.auto_addr = '0; m.auto_data = '0;
    ma.host_valid = 1'b0; ma.host_addr = '0; ma.host_data = '0;
    ma.auto_valid = 1'b0; ma.auto_addr = '0; ma.auto_data = '0;
    test_reset();
    test_single_write(4'h5, 8'hA7, "single");
    test_fifo_full();
    test_auto_while_busy();
    test_reset_in_high();
    test_arbitration();
    test_random();
    test_alt_timing();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
